// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder for a CPU memory stage.
// Accepts one load/store, waits a fixed latency, then holds the response until consumed.
module dm_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_type,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] TYPE_WORD = 2'd0;
    localparam logic [1:0] TYPE_HALF = 2'd1;
    localparam logic [1:0] TYPE_BYTE = 2'd2;
    localparam logic [1:0] TYPE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;

    logic        lat_we;
    logic [1:0]  lat_type;
    logic        lat_sign;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [0:DEPTH-1];

    logic                  commit;
    logic                  access_err;
    logic [DEPTH_LOG2-1:0] word_index;
    logic [31:0]           read_word;
    logic [31:0]           load_value;
    logic [3:0]            write_strobe;
    logic [31:0]           write_lanes;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;

    assign commit     = (state == BUSY) && (count == 4'd0);
    assign word_index = lat_addr[DEPTH_LOG2+1:2];
    assign read_word  = mem[word_index];

    // Rejection rules: reserved size, misalignment, or any address bit above the storage range.
    always_comb begin
        access_err = 1'b0;
        if (lat_type == TYPE_RSVD) begin
            access_err = 1'b1;
        end
        if ((lat_type == TYPE_WORD) && (lat_addr[1:0] != 2'b00)) begin
            access_err = 1'b1;
        end
        if ((lat_type == TYPE_HALF) && lat_addr[0]) begin
            access_err = 1'b1;
        end
        if (|lat_addr[31:DEPTH_LOG2+2]) begin
            access_err = 1'b1;
        end
    end

    // Lane selection and extension for loads.
    always_comb begin
        half_sel   = lat_addr[1] ? read_word[31:16] : read_word[15:0];
        byte_sel   = 8'h00;
        load_value = 32'h0;
        case (lat_addr[1:0])
            2'd0:    byte_sel = read_word[7:0];
            2'd1:    byte_sel = read_word[15:8];
            2'd2:    byte_sel = read_word[23:16];
            default: byte_sel = read_word[31:24];
        endcase
        case (lat_type)
            TYPE_WORD: load_value = read_word;
            TYPE_HALF: load_value = {{16{lat_sign & half_sel[15]}}, half_sel};
            TYPE_BYTE: load_value = {{24{lat_sign & byte_sel[7]}}, byte_sel};
            default:   load_value = 32'h0;
        endcase
    end

    // Byte-lane strobes and replicated store data; errored or load requests write nothing.
    always_comb begin
        write_strobe = 4'b0000;
        write_lanes  = lat_wdata;
        case (lat_type)
            TYPE_WORD: begin
                write_strobe = 4'b1111;
                write_lanes  = lat_wdata;
            end
            TYPE_HALF: begin
                write_strobe = lat_addr[1] ? 4'b1100 : 4'b0011;
                write_lanes  = {2{lat_wdata[15:0]}};
            end
            TYPE_BYTE: begin
                write_strobe = 4'b0001 << lat_addr[1:0];
                write_lanes  = {4{lat_wdata[7:0]}};
            end
            default: begin
                write_strobe = 4'b0000;
                write_lanes  = lat_wdata;
            end
        endcase
        if (!lat_we || access_err) begin
            write_strobe = 4'b0000;
        end
    end

    // Storage is deliberately not reset; reset only stops a pending commit via the FSM.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (write_strobe[b]) begin
                    mem[word_index][8*b +: 8] <= write_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_type   <= TYPE_WORD;
            lat_sign   <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we     <= req_we;
                        lat_type   <= req_type;
                        lat_sign   <= req_sign;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        count      <= COUNT_LOAD;
                        req_ready  <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= access_err;
                        resp_rdata <= (access_err || lat_we) ? 32'h0 : load_value;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
